// File: rtl/bullet_pool_pkg.sv
// Shared constants for the bullet pool: screen/object widths, lane bit indices,
// fire modes and bullet colours.
package bullet_pool_pkg;

    localparam int OBJ_X_POS_BIT_LEN = 10;
    localparam int OBJ_Y_POS_BIT_LEN = 10;
    localparam int H_DISP_LEN        = 10;
    localparam int V_DISP_LEN        = 10;
    localparam int COLOR_RGB_DEPTH   = 12;

    localparam int BULLET_CENTER = 0;
    localparam int BULLET_LEFT   = 1;
    localparam int BULLET_RIGHT  = 2;

    localparam logic [COLOR_RGB_DEPTH-1:0] BULLET_SINGLE_COLOR = 12'hFF0;
    localparam logic [COLOR_RGB_DEPTH-1:0] BULLET_DOUBLE_COLOR = 12'h0FF;

    typedef enum logic [1:0] {
        MODE_SINGLE     = 2'd0,
        MODE_DOUBLE     = 2'd1,
        MODE_TRIPLE     = 2'd2,
        MODE_TRIPLE_ALT = 2'd3
    } mode_e;

    typedef logic [2:0] lane_mask_t;

    // Double mode fires only the two side lanes; both triple encodings fire all three.
    function automatic lane_mask_t mode_to_mask(input mode_e mode);
        case (mode)
            MODE_SINGLE: return 3'b001;
            MODE_DOUBLE: return 3'b110;
            default:     return 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/bullet_pool_if.sv
// Player/control inputs, pixel query and video/status outputs of the bullet pool.
interface bullet_pool_if
    import bullet_pool_pkg::*;
#(
    parameter int BULLET_NUM = 8
);

    localparam int IDX_W = $clog2(BULLET_NUM);
    localparam int CNT_W = $clog2(BULLET_NUM + 1);

    logic [OBJ_X_POS_BIT_LEN-1:0] me_x_pos_i;
    logic [OBJ_Y_POS_BIT_LEN-1:0] me_y_pos_i;
    logic [H_DISP_LEN-1:0]        req_x_addr_i;
    logic [V_DISP_LEN-1:0]        req_y_addr_i;
    logic [1:0]                   mode_i;
    logic                         fire_en_i;
    logic                         move_tick_i;
    logic                         kill_valid_i;
    logic [IDX_W-1:0]             kill_idx_i;
    logic [COLOR_RGB_DEPTH-1:0]   vga_rgb_o;
    logic                         vga_alpha_o;
    logic                         shot_o;
    logic                         drop_o;
    logic [CNT_W-1:0]             active_cnt_o;

    modport master (
        output me_x_pos_i, me_y_pos_i, req_x_addr_i, req_y_addr_i, mode_i,
               fire_en_i, move_tick_i, kill_valid_i, kill_idx_i,
        input  vga_rgb_o, vga_alpha_o, shot_o, drop_o, active_cnt_o
    );

    modport slave (
        input  me_x_pos_i, me_y_pos_i, req_x_addr_i, req_y_addr_i, mode_i,
               fire_en_i, move_tick_i, kill_valid_i, kill_idx_i,
        output vga_rgb_o, vga_alpha_o, shot_o, drop_o, active_cnt_o
    );

endinterface

// File: rtl/bullet_pool_slot.sv
// One bullet slot: position and lane mask, the spawn/kill/move update,
// and the three-lane pixel hit test against the current state.
module bullet_pool_slot
    import bullet_pool_pkg::*;
#(
    parameter int SPEED        = 5,
    parameter int BULLET_W     = 4,
    parameter int BULLET_H     = 8,
    parameter int LANE_SPACING = 12
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         spawn,
    input  logic [OBJ_X_POS_BIT_LEN-1:0] spawn_x,
    input  logic [OBJ_Y_POS_BIT_LEN-1:0] spawn_y,
    input  lane_mask_t                   spawn_mask,
    input  logic                         move,
    input  logic                         kill,
    input  logic [H_DISP_LEN-1:0]        req_x,
    input  logic [V_DISP_LEN-1:0]        req_y,
    output lane_mask_t                   mask,
    output lane_mask_t                   mask_next,
    output logic                         hit_center,
    output logic                         hit_side
);

    localparam logic [OBJ_Y_POS_BIT_LEN-1:0] STEP = OBJ_Y_POS_BIT_LEN'(SPEED);

    logic [OBJ_X_POS_BIT_LEN-1:0] x_q, x_d;
    logic [OBJ_Y_POS_BIT_LEN-1:0] y_q, y_d;
    lane_mask_t                   mask_q, mask_d;

    int   cx, cy, rx, ry;
    logic row_hit;

    function automatic logic in_span(input int pos, input int lo, input int len);
        return (pos >= lo) && (pos < lo + len);
    endfunction

    // Spawn only ever targets a free slot, so it cannot collide with a real kill.
    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        mask_d = mask_q;
        if (spawn) begin
            x_d    = spawn_x;
            y_d    = spawn_y;
            mask_d = spawn_mask;
        end else if (kill) begin
            mask_d = '0;
        end else if (move && (mask_q != '0)) begin
            if (y_q >= STEP) begin
                y_d = y_q - STEP;
            end else begin
                mask_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q    <= '0;
            y_q    <= '0;
            mask_q <= '0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            mask_q <= mask_d;
        end
    end

    // Signed compare: a left lane left of column 0 must not wrap round to the right edge.
    always_comb begin
        cx         = int'(x_q);
        cy         = int'(y_q);
        rx         = int'(req_x);
        ry         = int'(req_y);
        row_hit    = in_span(ry, cy, BULLET_H);
        hit_center = row_hit && mask_q[BULLET_CENTER] && in_span(rx, cx, BULLET_W);
        hit_side   = row_hit &&
                     ((mask_q[BULLET_LEFT]  && in_span(rx, cx - LANE_SPACING, BULLET_W)) ||
                      (mask_q[BULLET_RIGHT] && in_span(rx, cx + LANE_SPACING, BULLET_W)));
    end

    assign mask      = mask_q;
    assign mask_next = mask_d;

endmodule

// File: rtl/bullet_pool.sv
// Pool of player bullets: periodic shots into the lowest free slot, frame-strobed
// movement, per-slot kills, and a registered per-pixel alpha/colour answer.
module bullet_pool
    import bullet_pool_pkg::*;
#(
    parameter int BULLET_NUM      = 8,
    parameter int SPEED           = 5,
    parameter int SHOOT_PERIOD    = 12,
    parameter int BULLET_W        = 4,
    parameter int BULLET_H        = 8,
    parameter int LANE_SPACING    = 12,
    parameter int X_OFFSET        = 14,
    parameter int Y_OFFSET_SINGLE = 0,
    parameter int Y_OFFSET_MULTI  = 6
) (
    input logic         clk,
    input logic         rst,
    bullet_pool_if.slave bus
);

    localparam int IDX_W = $clog2(BULLET_NUM);
    localparam int CNT_W = $clog2(BULLET_NUM + 1);
    localparam int CTR_W = (SHOOT_PERIOD > 1) ? $clog2(SHOOT_PERIOD) : 1;

    localparam logic [CTR_W-1:0]             CTR_LAST = CTR_W'(SHOOT_PERIOD - 1);
    localparam logic [OBJ_X_POS_BIT_LEN-1:0] X_OFF    = OBJ_X_POS_BIT_LEN'(X_OFFSET);
    localparam logic [OBJ_Y_POS_BIT_LEN-1:0] Y_OFF_S  = OBJ_Y_POS_BIT_LEN'(Y_OFFSET_SINGLE);
    localparam logic [OBJ_Y_POS_BIT_LEN-1:0] Y_OFF_M  = OBJ_Y_POS_BIT_LEN'(Y_OFFSET_MULTI);

    mode_e                        mode;
    logic [CTR_W-1:0]             shoot_cnt_q, shoot_cnt_d;
    logic                         attempt;
    logic                         any_free;
    logic [BULLET_NUM-1:0]        spawn_vec;
    logic [BULLET_NUM-1:0]        kill_vec;
    logic [OBJ_X_POS_BIT_LEN-1:0] spawn_x;
    logic [OBJ_Y_POS_BIT_LEN-1:0] spawn_y;
    lane_mask_t                   spawn_mask;
    lane_mask_t                   slot_mask      [BULLET_NUM];
    lane_mask_t                   slot_mask_next [BULLET_NUM];
    logic [BULLET_NUM-1:0]        hit_center;
    logic [BULLET_NUM-1:0]        hit_side;
    logic [CNT_W-1:0]             cnt_d;
    logic                         alpha_d;

    logic [COLOR_RGB_DEPTH-1:0]   rgb_q;
    logic                         alpha_q;
    logic                         shot_q;
    logic                         drop_q;
    logic [CNT_W-1:0]             cnt_q;

    assign mode = mode_e'(bus.mode_i);

    // A shot attempt is the wrap of the counter; a paused fire_en keeps its phase.
    always_comb begin
        shoot_cnt_d = shoot_cnt_q;
        attempt     = 1'b0;
        if (bus.move_tick_i && bus.fire_en_i) begin
            if (shoot_cnt_q == CTR_LAST) begin
                shoot_cnt_d = '0;
                attempt     = 1'b1;
            end else begin
                shoot_cnt_d = shoot_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        any_free  = 1'b0;
        spawn_vec = '0;
        for (int i = 0; i < BULLET_NUM; i++) begin
            if (!any_free && (slot_mask[i] == '0)) begin
                any_free     = 1'b1;
                spawn_vec[i] = attempt;
            end
        end
    end

    always_comb begin
        kill_vec = '0;
        for (int i = 0; i < BULLET_NUM; i++) begin
            kill_vec[i] = bus.kill_valid_i && (bus.kill_idx_i == IDX_W'(i));
        end
    end

    assign spawn_x    = bus.me_x_pos_i + X_OFF;
    assign spawn_y    = bus.me_y_pos_i + ((mode == MODE_SINGLE) ? Y_OFF_S : Y_OFF_M);
    assign spawn_mask = mode_to_mask(mode);

    for (genvar g = 0; g < BULLET_NUM; g++) begin : g_slot
        bullet_pool_slot #(
            .SPEED        (SPEED),
            .BULLET_W     (BULLET_W),
            .BULLET_H     (BULLET_H),
            .LANE_SPACING (LANE_SPACING)
        ) u_slot (
            .clk        (clk),
            .rst        (rst),
            .spawn      (spawn_vec[g]),
            .spawn_x    (spawn_x),
            .spawn_y    (spawn_y),
            .spawn_mask (spawn_mask),
            .move       (bus.move_tick_i),
            .kill       (kill_vec[g]),
            .req_x      (bus.req_x_addr_i),
            .req_y      (bus.req_y_addr_i),
            .mask       (slot_mask[g]),
            .mask_next  (slot_mask_next[g]),
            .hit_center (hit_center[g]),
            .hit_side   (hit_side[g])
        );
    end

    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < BULLET_NUM; i++) begin
            cnt_d = cnt_d + CNT_W'(slot_mask_next[i] != '0);
        end
    end

    assign alpha_d = (|hit_center) || (|hit_side);

    // Colour only changes on a covered pixel so the compositor sees a stable value otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shoot_cnt_q <= '0;
            rgb_q       <= '0;
            alpha_q     <= 1'b0;
            shot_q      <= 1'b0;
            drop_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            shoot_cnt_q <= shoot_cnt_d;
            alpha_q     <= alpha_d;
            shot_q      <= attempt && any_free;
            drop_q      <= attempt && !any_free;
            cnt_q       <= cnt_d;
            if (alpha_d) begin
                rgb_q <= (|hit_center) ? BULLET_SINGLE_COLOR : BULLET_DOUBLE_COLOR;
            end
        end
    end

    assign bus.vga_rgb_o    = rgb_q;
    assign bus.vga_alpha_o  = alpha_q;
    assign bus.shot_o       = shot_q;
    assign bus.drop_o       = drop_q;
    assign bus.active_cnt_o = cnt_q;

endmodule

// File: tb/tb_bullet_pool.sv
// Bullet pool bench: directed and random stimulus checked each cycle against a
// slot-array reference model built from the behavioural rules.
module tb_bullet_pool;
    import bullet_pool_pkg::*;

    localparam int BN    = 4;
    localparam int SPEED = 5;
    localparam int SP    = 12;
    localparam int BW    = 4;
    localparam int BH    = 8;
    localparam int LS    = 12;
    localparam int XO    = 14;
    localparam int YOS   = 0;
    localparam int YOM   = 6;
    localparam int SCR   = 1024;

    logic clk;
    logic rst;

    bullet_pool_if #(.BULLET_NUM(BN)) bus ();

    bullet_pool #(
        .BULLET_NUM      (BN),
        .SPEED           (SPEED),
        .SHOOT_PERIOD    (SP),
        .BULLET_W        (BW),
        .BULLET_H        (BH),
        .LANE_SPACING    (LS),
        .X_OFFSET        (XO),
        .Y_OFFSET_SINGLE (YOS),
        .Y_OFFSET_MULTI  (YOM)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         mx [BN];
    int         my [BN];
    logic [2:0] mm [BN];
    int         ctr;

    logic [11:0] exp_rgb;
    logic        exp_alpha;
    logic        exp_shot;
    logic        exp_drop;
    int          exp_cnt;

    int total;
    int bad;
    int cyc;
    int phase;
    int shot_seen;
    int drop_seen;

    int q3x [10] = '{102, 114, 126, 126, 105, 106, 101, 126, 117, 118};
    int q3y [10] = '{300, 300, 307, 308, 300, 300, 300, 299, 303, 303};
    int q4x [13] = '{1021, 1022, 1023, 0, 4, 5, 8, 9, 17, 20, 21, 5, 5};
    int q4y [13] = '{306, 310, 313, 306, 306, 306, 306, 306, 306, 306, 306, 314, 305};

    task automatic checkOutput(input string tag, input int obs, input int expv);
        total++;
        if (obs != expv) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d (phase %0d cycle %0d)", tag, obs, expv, phase, cyc);
        end
    endtask

    task automatic checkAll();
        checkOutput("rgb",    int'(bus.vga_rgb_o),    int'(exp_rgb));
        checkOutput("alpha",  int'(bus.vga_alpha_o),  int'(exp_alpha));
        checkOutput("shot",   int'(bus.shot_o),       int'(exp_shot));
        checkOutput("drop",   int'(bus.drop_o),       int'(exp_drop));
        checkOutput("active", int'(bus.active_cnt_o), exp_cnt);
        if (bus.shot_o) shot_seen++;
        if (bus.drop_o) drop_seen++;
    endtask

    task automatic modelReset();
        for (int s = 0; s < BN; s++) begin
            mx[s] = 0;
            my[s] = 0;
            mm[s] = 3'b000;
        end
        ctr       = 0;
        exp_rgb   = '0;
        exp_alpha = 1'b0;
        exp_shot  = 1'b0;
        exp_drop  = 1'b0;
        exp_cnt   = 0;
    endtask

    // Reference: query on the old state, then counter, lowest free slot, per-slot update.
    task automatic modelStep();
        int   rx, ry, lx, free_slot, off;
        logic hit, cen, attempt;
        rx  = int'(bus.req_x_addr_i);
        ry  = int'(bus.req_y_addr_i);
        hit = 1'b0;
        cen = 1'b0;
        for (int s = 0; s < BN; s++) begin
            if (ry >= my[s] && ry < my[s] + BH) begin
                for (int l = 0; l < 3; l++) begin
                    if (mm[s][l]) begin
                        lx = mx[s] + ((l == 0) ? 0 : (l == 1) ? -LS : LS);
                        if (rx >= lx && rx < lx + BW) begin
                            hit = 1'b1;
                            if (l == 0) cen = 1'b1;
                        end
                    end
                end
            end
        end
        exp_alpha = hit;
        if (hit) exp_rgb = cen ? BULLET_SINGLE_COLOR : BULLET_DOUBLE_COLOR;

        attempt = 1'b0;
        if (bus.move_tick_i && bus.fire_en_i) begin
            if (ctr == SP - 1) begin
                ctr     = 0;
                attempt = 1'b1;
            end else begin
                ctr++;
            end
        end
        free_slot = -1;
        for (int s = BN - 1; s >= 0; s--) if (mm[s] == 3'b000) free_slot = s;
        exp_shot = attempt && (free_slot >= 0);
        exp_drop = attempt && (free_slot < 0);

        for (int s = 0; s < BN; s++) begin
            if (exp_shot && s == free_slot) begin
                off   = (bus.mode_i == 2'd0) ? YOS : YOM;
                mx[s] = (int'(bus.me_x_pos_i) + XO) % SCR;
                my[s] = (int'(bus.me_y_pos_i) + off) % SCR;
                mm[s] = (bus.mode_i == 2'd0) ? 3'b001 : (bus.mode_i == 2'd1) ? 3'b110 : 3'b111;
            end else if (bus.kill_valid_i && int'(bus.kill_idx_i) == s) begin
                mm[s] = 3'b000;
            end else if (bus.move_tick_i && mm[s] != 3'b000) begin
                if (my[s] >= SPEED) my[s] = my[s] - SPEED;
                else                mm[s] = 3'b000;
            end
        end
        exp_cnt = 0;
        for (int s = 0; s < BN; s++) if (mm[s] != 3'b000) exp_cnt++;
    endtask

    task automatic setQuery(input int qx, input int qy);
        bus.req_x_addr_i = H_DISP_LEN'((qx + 2 * SCR) % SCR);
        bus.req_y_addr_i = V_DISP_LEN'((qy + 2 * SCR) % SCR);
    endtask

    // Mostly aim at a live lane edge so hits and near-misses both occur often.
    task automatic aimQuery();
        int act[$];
        int s, off;
        for (int i = 0; i < BN; i++) if (mm[i] != 3'b000) act.push_back(i);
        if (act.size() == 0 || $urandom_range(0, 3) == 0) begin
            setQuery(int'($urandom_range(0, SCR - 1)), int'($urandom_range(0, SCR - 1)));
        end else begin
            s = act[$urandom_range(0, act.size() - 1)];
            case ($urandom_range(0, 2))
                0:       off = 0;
                1:       off = -LS;
                default: off = LS;
            endcase
            setQuery(mx[s] + off + int'($urandom_range(0, 7)) - 2,
                     my[s] + int'($urandom_range(0, 11)) - 2);
        end
    endtask

    task automatic applyStimulus();
        bus.kill_valid_i = 1'b0;
        bus.kill_idx_i   = '0;
        aimQuery();
        case (phase)
            1: begin
                bus.move_tick_i = (cyc % 4 == 0);
                bus.fire_en_i   = 1'b1;
                bus.mode_i      = 2'd0;
                bus.me_x_pos_i  = OBJ_X_POS_BIT_LEN'(100);
                bus.me_y_pos_i  = OBJ_Y_POS_BIT_LEN'(400);
                if (cyc == 250) begin
                    bus.kill_valid_i = 1'b1;
                    bus.kill_idx_i   = 2'd2;
                end
            end
            2: begin
                bus.move_tick_i  = ($urandom_range(0, 9) < 3);
                bus.fire_en_i    = ($urandom_range(0, 9) != 0);
                bus.mode_i       = 2'($urandom_range(0, 3));
                bus.me_x_pos_i   = OBJ_X_POS_BIT_LEN'($urandom_range(0, SCR - 1));
                bus.me_y_pos_i   = OBJ_Y_POS_BIT_LEN'(($urandom_range(0, 4) == 0) ?
                                   $urandom_range(0, SCR - 1) : $urandom_range(0, 40));
                bus.kill_valid_i = ($urandom_range(0, 6) == 0);
                bus.kill_idx_i   = 2'($urandom_range(0, BN - 1));
            end
            3: begin
                bus.move_tick_i = (cyc % 2 == 0) && (cyc < 24 || cyc == 40);
                bus.fire_en_i   = 1'b1;
                bus.mode_i      = 2'd1;
                bus.me_x_pos_i  = OBJ_X_POS_BIT_LEN'(100);
                bus.me_y_pos_i  = OBJ_Y_POS_BIT_LEN'(294);
                if (cyc >= 24 && cyc < 40) setQuery(q3x[(cyc - 24) % 10], q3y[(cyc - 24) % 10]);
                if (cyc == 40) begin
                    bus.kill_valid_i = 1'b1;
                    bus.kill_idx_i   = 2'd0;
                end
            end
            default: begin
                bus.move_tick_i = (cyc % 2 == 0) && (cyc < 24 || cyc == 50);
                bus.fire_en_i   = 1'b1;
                bus.mode_i      = 2'd2;
                bus.me_x_pos_i  = OBJ_X_POS_BIT_LEN'(1015);
                bus.me_y_pos_i  = OBJ_Y_POS_BIT_LEN'(300);
                if (cyc >= 24 && cyc < 50) setQuery(q4x[(cyc - 24) % 13], q4y[(cyc - 24) % 13]);
                if (cyc == 50) begin
                    bus.kill_valid_i = 1'b1;
                    bus.kill_idx_i   = 2'd0;
                end
            end
        endcase
    endtask

    task automatic stepCycle();
        applyStimulus();
        modelStep();
        @(negedge clk);
        checkAll();
        cyc++;
    endtask

    task automatic midReset();
        rst = 1'b1;
        #1;
        modelReset();
        checkAll();
        @(negedge clk);
        rst       = 1'b0;
        cyc       = 0;
        shot_seen = 0;
        drop_seen = 0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        phase = 0;
        shot_seen = 0;
        drop_seen = 0;
        rst   = 1'b1;
        bus.me_x_pos_i   = '0;
        bus.me_y_pos_i   = '0;
        bus.req_x_addr_i = '0;
        bus.req_y_addr_i = '0;
        bus.mode_i       = '0;
        bus.fire_en_i    = 1'b0;
        bus.move_tick_i  = 1'b0;
        bus.kill_valid_i = 1'b0;
        bus.kill_idx_i   = '0;
        modelReset();
        repeat (3) @(negedge clk);
        checkAll();
        rst = 1'b0;

        phase = 1;
        shot_seen = 0;
        drop_seen = 0;
        repeat (300) stepCycle();
        checkOutput("p1_shots",  shot_seen, 5);
        checkOutput("p1_drops",  drop_seen, 1);
        checkOutput("p1_active", int'(bus.active_cnt_o), 4);

        phase = 2;
        cyc   = 0;
        repeat (1500) stepCycle();
        midReset();

        phase = 3;
        repeat (60) stepCycle();
        checkOutput("p3_shots", shot_seen, 1);
        midReset();

        phase = 4;
        repeat (80) stepCycle();
        checkOutput("p4_shots", shot_seen, 1);
        checkOutput("p4_active", int'(bus.active_cnt_o), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
